// File: rtl/dnn_sample_feeder.sv
// Ping-pong sample buffer feeding the DNN one training sample per cycle block.
// Define DNN_FEEDER_STATS_EN to build the saturating underflow/sample counters.
module dnn_sample_feeder #(
    parameter int width    = 16,
    parameter int width_in = 8,
    parameter int A        = 4,
    parameter int Y        = 1,
    parameter int cpc      = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [$clog2(cpc)-1:0]  cycle_index,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [width_in*A-1:0]   s_act,
    input  logic [Y-1:0]            s_y,
    input  logic [width-1:0]        s_eta,
    output logic [width_in*A-1:0]   a_in,
    output logic [Y-1:0]            y_in,
    output logic [width-1:0]        eta_in,
    output logic                    feed_active,
    output logic [width-1:0]        underflow_cnt,
    output logic [width-1:0]        samples_cnt
);

    localparam int B  = cpc - 2;
    localparam int CW = $clog2(cpc);
    localparam int BW = (B > 1) ? $clog2(B) : 1;

    localparam logic [CW-1:0] LAST_IDX  = CW'(cpc - 1);
    localparam logic [CW-1:0] NUM_BEATS = CW'(B);
    localparam logic [BW-1:0] LAST_BEAT = BW'(B - 1);

    logic [width_in*A-1:0] act_mem [0:1][0:B-1];
    logic [Y-1:0]          y_mem   [0:1][0:B-1];
    logic [width-1:0]      eta_mem [0:1];

    logic [1:0]       full;
    logic             wr_bank;
    logic             rd_bank;
    logic             active;
    logic [BW-1:0]    beat;
    logic [width-1:0] eta_reg;

    logic accept;
    logic boundary;
    logic last_beat;
    logic next_bank;
    logic next_active;

    assign s_ready   = !reset && !full[wr_bank];
    assign accept    = s_valid && s_ready;
    assign boundary  = (cycle_index == LAST_IDX);
    assign last_beat = (beat == LAST_BEAT);

    // An active bank is released at the boundary, so the candidate is always the other bank.
    assign next_bank   = active ? ~rd_bank : rd_bank;
    assign next_active = full[next_bank];

    always_ff @(posedge clk) begin
        if (accept) begin
            act_mem[wr_bank][beat] <= s_act;
            y_mem[wr_bank][beat]   <= s_y;
            if (beat == '0) begin
                eta_mem[wr_bank] <= s_eta;
            end
        end
    end

    // The boundary only ever clears the read bank and a completing write only sets the
    // write bank; both use the pre-edge flags, so a sample finishing on the boundary waits a block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            beat    <= '0;
            active  <= 1'b0;
            eta_reg <= '0;
        end else begin
            if (boundary) begin
                if (active) begin
                    full[rd_bank] <= 1'b0;
                end
                rd_bank <= next_bank;
                active  <= next_active;
                eta_reg <= next_active ? eta_mem[next_bank] : '0;
            end
            if (accept) begin
                if (last_beat) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    beat          <= '0;
                end else begin
                    beat <= beat + BW'(1);
                end
            end
        end
    end

    always_comb begin
        a_in = '0;
        y_in = '0;
        if (active && (cycle_index < NUM_BEATS)) begin
            a_in = act_mem[rd_bank][cycle_index[BW-1:0]];
            y_in = y_mem[rd_bank][cycle_index[BW-1:0]];
        end
    end

    assign eta_in      = eta_reg;
    assign feed_active = active;

`ifdef DNN_FEEDER_STATS_EN
    logic [width-1:0] underflow_q;
    logic [width-1:0] samples_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underflow_q <= '0;
            samples_q   <= '0;
        end else if (boundary) begin
            if (next_active) begin
                if (samples_q != '1) begin
                    samples_q <= samples_q + width'(1);
                end
            end else if (underflow_q != '1) begin
                underflow_q <= underflow_q + width'(1);
            end
        end
    end

    assign underflow_cnt = underflow_q;
    assign samples_cnt   = samples_q;
`else
    assign underflow_cnt = '0;
    assign samples_cnt   = '0;
`endif

endmodule

// File: tb/tb_dnn_sample_feeder.sv
// Directed bench for dnn_sample_feeder: vector table for the basic replay, then
// hand-sequenced back-to-back, reset, boundary-race and stalled-host scenarios.
module tb_dnn_sample_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  cycle_index;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_act;
    logic [0:0]  s_y;
    logic [15:0] s_eta;
    logic [31:0] a_in;
    logic [0:0]  y_in;
    logic [15:0] eta_in;
    logic        feed_active;
    logic [15:0] underflow_cnt;
    logic [15:0] samples_cnt;

    always #5 clk = ~clk;

    dnn_sample_feeder dut (
        .clk(clk),
        .reset(reset),
        .cycle_index(cycle_index),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_act(s_act),
        .s_y(s_y),
        .s_eta(s_eta),
        .a_in(a_in),
        .y_in(y_in),
        .eta_in(eta_in),
        .feed_active(feed_active),
        .underflow_cnt(underflow_cnt),
        .samples_cnt(samples_cnt)
    );

    typedef struct {
        logic [2:0]  idx;
        logic        valid;
        logic [31:0] act;
        logic        y;
        logic [15:0] eta;
        logic [31:0] expA;
        logic        expY;
        logic [15:0] expEta;
        logic        expFeed;
        logic        expRdy;
    } vec_t;

    vec_t vecs[$];

    int   checks = 0;
    int   errors = 0;
    int   ci;
    int   sent;
    int   total;
    int   baseId;
    logic hostEn;
    logic stall;
    logic phase;
    logic rdyLog [0:5];

    function automatic logic [31:0] actOf(input int id, input int b);
        return 32'hA0B00000 + 32'(id) * 32'h100 + 32'(b);
    endfunction

    function automatic logic yOf(input int id, input int b);
        int s;
        s = id + b;
        return s[0];
    endfunction

    function automatic logic [15:0] etaOf(input int id);
        return 16'h0200 + 16'(id);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t ci=%0d: got %h, expected %h", name, $time, cycle_index, actual, expected);
        end
    endtask

    // Host model: streams 4-beat samples, optionally stalling every other cycle.
    task automatic applyStimulus();
        int b;
        int id;
        cycle_index = 3'(ci);
        if (hostEn && (sent < 4 * total) && (!stall || !phase)) begin
            b       = sent % 4;
            id      = baseId + sent / 4;
            s_valid = 1'b1;
            s_act   = actOf(id, b);
            s_y     = yOf(id, b);
            s_eta   = (b == 0) ? etaOf(id) : 16'hBEEF;
        end else begin
            s_valid = 1'b0;
            s_act   = 32'hDEADBEEF;
            s_y     = 1'b1;
            s_eta   = 16'hBEEF;
        end
        #1;
    endtask

    task automatic runBlock(input int expId, input int n);
        logic        acc;
        logic [31:0] expA;
        logic        expY;
        logic [15:0] expEta;
        logic        expFeed;
        for (int i = 0; i < n; i++) begin
            applyStimulus();
            expA = '0; expY = 1'b0; expEta = '0; expFeed = 1'b0;
            if (expId >= 0) begin
                expFeed = 1'b1;
                expEta  = etaOf(expId);
                if (ci < 4) begin
                    expA = actOf(expId, ci);
                    expY = yOf(expId, ci);
                end
            end
            checkOutput("a_in", a_in, expA);
            checkOutput("y_in", 32'(y_in), 32'(expY));
            checkOutput("eta_in", 32'(eta_in), 32'(expEta));
            checkOutput("feed_active", 32'(feed_active), 32'(expFeed));
            rdyLog[ci] = s_ready;
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            if (stall) phase = ~phase;
            ci = (ci == 5) ? 0 : ci + 1;
        end
    endtask

    initial begin
        vec_t v;
        for (int blk = 0; blk < 3; blk++) begin
            for (int c = 0; c < 6; c++) begin
                v.idx     = 3'(c);
                v.valid   = (blk == 0) && (c < 4);
                v.act     = v.valid ? 32'h04030201 + 32'(c) * 32'h04040404 : 32'h0;
                v.y       = v.valid ? 1'(c & 1) : 1'b0;
                v.eta     = (c == 0) ? 16'h0100 : 16'hFFFF;
                v.expA    = '0;
                v.expY    = 1'b0;
                v.expEta  = '0;
                v.expFeed = (blk == 1);
                v.expRdy  = 1'b1;
                if (blk == 1) begin
                    v.expEta = 16'h0100;
                    if (c < 4) begin
                        v.expA = 32'h04030201 + 32'(c) * 32'h04040404;
                        v.expY = 1'(c & 1);
                    end
                end
                vecs.push_back(v);
            end
        end

        hostEn = 1'b0; stall = 1'b0; phase = 1'b0;
        sent = 0; total = 0; baseId = 0; ci = 0;
        reset = 1'b1; s_valid = 1'b0; cycle_index = '0;
        s_act = '0; s_y = '0; s_eta = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_s_ready", 32'(s_ready), 32'd0);
        checkOutput("reset_feed", 32'(feed_active), 32'd0);
        checkOutput("reset_eta", 32'(eta_in), 32'd0);
        checkOutput("reset_a_in", a_in, 32'd0);
        reset = 1'b0;

        // Single sample in block 0, replay in block 1, underflow in blocks 2 and 3.
        foreach (vecs[i]) begin
            cycle_index = vecs[i].idx;
            s_valid     = vecs[i].valid;
            s_act       = vecs[i].act;
            s_y         = vecs[i].y;
            s_eta       = vecs[i].eta;
            #1;
            checkOutput("vec_a_in", a_in, vecs[i].expA);
            checkOutput("vec_y_in", 32'(y_in), 32'(vecs[i].expY));
            checkOutput("vec_eta_in", 32'(eta_in), 32'(vecs[i].expEta));
            checkOutput("vec_feed", 32'(feed_active), 32'(vecs[i].expFeed));
            checkOutput("vec_s_ready", 32'(s_ready), 32'(vecs[i].expRdy));
            @(posedge clk);
            #1;
        end
`ifdef DNN_FEEDER_STATS_EN
        checkOutput("underflow_cnt", 32'(underflow_cnt), 32'd2);
        checkOutput("samples_cnt", 32'(samples_cnt), 32'd1);
`else
        checkOutput("underflow_cnt", 32'(underflow_cnt), 32'd0);
        checkOutput("samples_cnt", 32'(samples_cnt), 32'd0);
`endif

        // Back-to-back: three samples with s_valid held high.
        ci = 0; hostEn = 1'b1; sent = 0; total = 3; baseId = 0;
        runBlock(-1, 6);
        runBlock(0, 6);
        checkOutput("b2b_ready_ci1", 32'(rdyLog[1]), 32'd1);
        checkOutput("b2b_ready_ci2", 32'(rdyLog[2]), 32'd0);
        checkOutput("b2b_ready_ci5", 32'(rdyLog[5]), 32'd0);
        checkOutput("b2b_beats_before_stall", 32'(sent), 32'd8);
        runBlock(1, 6);
        checkOutput("b2b_ready_after_release", 32'(rdyLog[0]), 32'd1);
        checkOutput("b2b_beats_total", 32'(sent), 32'd12);
        runBlock(2, 3);
        checkOutput("b2b_pre_reset_feed", 32'(feed_active), 32'd1);

        // Reset in the middle of a feeding block.
        reset = 1'b1; hostEn = 1'b0; s_valid = 1'b0;
        #1;
        checkOutput("midreset_a_in", a_in, 32'd0);
        checkOutput("midreset_s_ready", 32'(s_ready), 32'd0);
        checkOutput("midreset_feed", 32'(feed_active), 32'd0);
        checkOutput("midreset_eta", 32'(eta_in), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0; ci = 0; cycle_index = '0;
        #1;
        checkOutput("postreset_s_ready", 32'(s_ready), 32'd1);
        checkOutput("postreset_feed", 32'(feed_active), 32'd0);
        checkOutput("postreset_eta", 32'(eta_in), 32'd0);
        checkOutput("postreset_underflow", 32'(underflow_cnt), 32'd0);

        // Race: last beat lands on the boundary edge, so the following block is null.
        runBlock(-1, 2);
        hostEn = 1'b1; sent = 0; total = 1; baseId = 5;
        runBlock(-1, 4);
        checkOutput("race_beats", 32'(sent), 32'd4);
        runBlock(-1, 6);

        // Stalled host: valid toggles while sample 5 is being fed.
        sent = 0; baseId = 7; stall = 1'b1; phase = 1'b0;
        runBlock(5, 6);
        runBlock(-1, 6);
        checkOutput("stall_beats", 32'(sent), 32'd4);
        runBlock(7, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
